// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite position controller: FSM encoding, key
// indices, default frame-interior bounds and per-axis step helpers.
package sprite_pkg;

  typedef enum logic [1:0] {
    StManual = 2'd0,
    StAuto   = 2'd1,
    StPause  = 2'd2
  } sprite_state_e;

  localparam int unsigned NumKeys  = 5;
  localparam int unsigned KeyUp    = 0;
  localparam int unsigned KeyDown  = 1;
  localparam int unsigned KeyLeft  = 2;
  localparam int unsigned KeyRight = 3;
  localparam int unsigned KeyPause = 4;

  // Interior of the blue/green frame drawn by the display stage, for a 31x31 marker.
  localparam int unsigned FrameXMin = 221;
  localparam int unsigned FrameXMax = 549;
  localparam int unsigned FrameYMin = 161;
  localparam int unsigned FrameYMax = 409;

  localparam int unsigned PosW  = 10;
  localparam int unsigned CalcW = 11;

  localparam logic [2:0] HitHold = 3'd7;

  typedef struct packed {
    logic [PosW-1:0] pos;
    logic            dir;  // 1 = +1, 0 = -1
  } axis_t;

  // Bounce step: advance by step in dir, clamp at a wall and flip direction on contact.
  function automatic axis_t bounce_step(input logic [PosW-1:0] pos, input logic dir,
                                        input logic [PosW-1:0] lo, input logic [PosW-1:0] hi,
                                        input logic [3:0] step);
    logic signed [CalcW-1:0] nxt;
    logic signed [CalcW-1:0] lo_s;
    logic signed [CalcW-1:0] hi_s;
    logic signed [CalcW-1:0] step_s;
    axis_t res;
    lo_s   = $signed({1'b0, lo});
    hi_s   = $signed({1'b0, hi});
    step_s = $signed({{(CalcW-4){1'b0}}, step});
    nxt    = dir ? ($signed({1'b0, pos}) + step_s) : ($signed({1'b0, pos}) - step_s);
    res.pos = nxt[PosW-1:0];
    res.dir = dir;
    if (nxt > hi_s) begin
      res.pos = hi;
      res.dir = 1'b0;
    end else if (nxt < lo_s) begin
      res.pos = lo;
      res.dir = 1'b1;
    end else if (nxt == hi_s || nxt == lo_s) begin
      res.dir = ~dir;
    end
    return res;
  endfunction

  // Manual step: opposing keys cancel, result saturates to [lo, hi].
  function automatic logic [PosW-1:0] manual_step(input logic [PosW-1:0] pos, input logic dec,
                                                  input logic inc, input logic [PosW-1:0] lo,
                                                  input logic [PosW-1:0] hi,
                                                  input logic [3:0] step);
    logic signed [CalcW-1:0] nxt;
    logic signed [CalcW-1:0] lo_s;
    logic signed [CalcW-1:0] hi_s;
    logic signed [CalcW-1:0] step_s;
    lo_s   = $signed({1'b0, lo});
    hi_s   = $signed({1'b0, hi});
    step_s = $signed({{(CalcW-4){1'b0}}, step});
    nxt    = $signed({1'b0, pos});
    if (inc && !dec) begin
      nxt = nxt + step_s;
    end else if (dec && !inc) begin
      nxt = nxt - step_s;
    end
    if (nxt > hi_s) begin
      nxt = hi_s;
    end else if (nxt < lo_s) begin
      nxt = lo_s;
    end
    return nxt[PosW-1:0];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for Width active-low keys: 2-flop synchronizer, shared sample strobe every
// DebCycles clocks, "held" when the last two samples are both low, and a one-cycle
// press pulse on the released-to-held transition.
module key_debounce #(
  parameter int unsigned Width     = 5,
  parameter int unsigned DebCycles = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] key_n_i,
  output logic [Width-1:0] held_o,
  output logic [Width-1:0] press_o
);

  localparam int unsigned CntW = (DebCycles > 1) ? $clog2(DebCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebCycles - 1);

  logic [Width-1:0] sync1_q, sync2_q;
  logic [Width-1:0] samp_new_q, samp_old_q;
  logic [Width-1:0] held_prev_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             strobe;
  logic [Width-1:0] held;

  // Free-running sample period counter; strobe on wrap.
  always_comb begin
    strobe = (cnt_q == CntLast);
    cnt_d  = strobe ? '0 : cnt_q + 1'b1;
  end

  // Synchronizer, sample history and previous held state; reset to all released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      samp_new_q  <= '1;
      samp_old_q  <= '1;
      held_prev_q <= '0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_n_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      held_prev_q <= held;
      if (strobe) begin
        samp_new_q <= sync2_q;
        samp_old_q <= samp_new_q;
      end
    end
  end

  // Held and press decode from registered samples.
  always_comb begin
    held    = ~samp_new_q & ~samp_old_q;
    held_o  = held;
    press_o = held & ~held_prev_q;
  end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: produces the top-left corner of the 31x31 marker once per
// frame (on the vsync falling edge), from pushbuttons (manual) or bouncing (auto), with pause.
// Build option: define SPRITE_HIT_FLAG_EN to enable the wall-contact hit flag; otherwise
// hit_o is tied low.
module sprite_pos_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned X_MIN      = FrameXMin,
  parameter int unsigned X_MAX      = FrameXMax,
  parameter int unsigned Y_MIN      = FrameYMin,
  parameter int unsigned Y_MAX      = FrameYMax,
  parameter int unsigned X_INIT     = 385,
  parameter int unsigned Y_INIT     = 285,
  parameter int unsigned STEP       = 2,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_i,
  input  logic [NumKeys-1:0] key_n_i,
  input  logic               auto_mode_i,
  output logic [PosW-1:0]    pos_x_o,
  output logic [PosW-1:0]    pos_y_o,
  output logic               frame_tick_o,
  output logic               hit_o
);

  localparam logic [PosW-1:0] XMinP  = PosW'(X_MIN);
  localparam logic [PosW-1:0] XMaxP  = PosW'(X_MAX);
  localparam logic [PosW-1:0] YMinP  = PosW'(Y_MIN);
  localparam logic [PosW-1:0] YMaxP  = PosW'(Y_MAX);
  localparam logic [PosW-1:0] XInitP = PosW'(X_INIT);
  localparam logic [PosW-1:0] YInitP = PosW'(Y_INIT);
  localparam logic [3:0]      StepP  = 4'(STEP);

  logic vs_sync1_q, vs_sync2_q, vs_prev_q;
  logic vs_fall;
  logic frame_tick_q;

  logic [NumKeys-1:0] key_held, key_press;
  logic               pause_evt;

  sprite_state_e state_q, state_d;

  logic [PosW-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic            flip;
  axis_t           ax, ay;

  key_debounce #(
    .Width     (NumKeys),
    .DebCycles (DEB_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (key_n_i),
    .held_o  (key_held),
    .press_o (key_press)
  );

  assign pause_evt = key_press[KeyPause];
  // Idle-high reset of the vsync chain avoids a spurious fall out of reset.
  assign vs_fall   = vs_prev_q & ~vs_sync2_q;

  // vsync synchronizer, edge history and registered frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync1_q   <= 1'b1;
      vs_sync2_q   <= 1'b1;
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      vs_sync1_q   <= vsync_i;
      vs_sync2_q   <= vs_sync1_q;
      vs_prev_q    <= vs_sync2_q;
      frame_tick_q <= vs_fall;
    end
  end

  // Mode FSM next state; dropping auto_mode overrides a coincident pause event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StManual: if (auto_mode_i) state_d = StAuto;
      StAuto: begin
        if (!auto_mode_i) state_d = StManual;
        else if (pause_evt) state_d = StPause;
      end
      StPause: begin
        if (!auto_mode_i) state_d = StManual;
        else if (pause_evt) state_d = StAuto;
      end
      default: state_d = StManual;
    endcase
  end

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StManual;
    else        state_q <= state_d;
  end

  // Per-frame motion; position and direction only move on a frame tick.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    flip    = 1'b0;
    ax      = bounce_step(pos_x_q, dir_x_q, XMinP, XMaxP, StepP);
    ay      = bounce_step(pos_y_q, dir_y_q, YMinP, YMaxP, StepP);
    if (frame_tick_q) begin
      case (state_q)
        StManual: begin
          pos_x_d = manual_step(pos_x_q, key_held[KeyLeft], key_held[KeyRight], XMinP, XMaxP,
                                StepP);
          pos_y_d = manual_step(pos_y_q, key_held[KeyUp], key_held[KeyDown], YMinP, YMaxP,
                                StepP);
        end
        StAuto: begin
          pos_x_d = ax.pos;
          pos_y_d = ay.pos;
          dir_x_d = ax.dir;
          dir_y_d = ay.dir;
          flip    = (ax.dir != dir_x_q) || (ay.dir != dir_y_q);
        end
        default: ;
      endcase
    end
  end

  // Position and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q <= XInitP;
      pos_y_q <= YInitP;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

`ifdef SPRITE_HIT_FLAG_EN
  logic [2:0] hit_cnt_q, hit_cnt_d;

  // Hit hold counter: reload on any auto-mode flip, count down on later frame ticks.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (flip) begin
      hit_cnt_d = HitHold;
    end else if (frame_tick_q && (hit_cnt_q != 3'd0)) begin
      hit_cnt_d = hit_cnt_q - 3'd1;
    end
  end

  // Hit hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_cnt_q <= 3'd0;
    else        hit_cnt_q <= hit_cnt_d;
  end

  assign hit_o = (hit_cnt_q != 3'd0);
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign hit_o       = 1'b0;
`endif

  // Pause only uses the press pulse; direction keys only use the held level.
  logic unused_keys;
  assign unused_keys = ^{key_press[KeyRight:KeyUp], key_held[KeyPause]};

  assign pos_x_o      = pos_x_q;
  assign pos_y_o      = pos_y_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed bench for sprite_pos_ctrl with DEB_CYCLES=4, STEP=2.
module tb_sprite_pos_ctrl;

`ifdef SPRITE_HIT_FLAG_EN
  localparam bit HitEn = 1'b1;
`else
  localparam bit HitEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic [4:0] key_n = 5'b11111;
  logic       auto_mode = 1'b0;
  logic [9:0] pos_x, pos_y;
  logic       frame_tick, hit;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_pos_ctrl #(
    .STEP       (2),
    .DEB_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (vsync),
    .key_n_i      (key_n),
    .auto_mode_i  (auto_mode),
    .pos_x_o      (pos_x),
    .pos_y_o      (pos_y),
    .frame_tick_o (frame_tick),
    .hit_o        (hit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 10-cycle frame: vsync falls just after an edge; reports edge index of first tick
  // and how many sampled cycles the tick was high.
  task automatic run_frame(output int first, output int width);
    first = -1;
    width = 0;
    @(posedge clk);
    #1 vsync = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (frame_tick) begin
        if (first < 0) first = i;
        width++;
      end
      if (i == 4) vsync = 1'b1;
    end
  endtask

  task automatic set_keys(input logic [4:0] k);
    @(posedge clk);
    #1 key_n = k;
    tick(16);
  endtask

  task automatic test_reset;
    int first, width;
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (pos_x !== 10'd385) begin n_bad++; $display("FAIL rst_pos_x got %0d want 385", pos_x); end
    n_cmp++; if (pos_y !== 10'd285) begin n_bad++; $display("FAIL rst_pos_y got %0d want 285", pos_y); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick got %b want 0", frame_tick); end
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit got %b want 0", hit); end
    rst_n = 1'b1;
    tick(4);
    for (int f = 0; f < 3; f++) begin
      run_frame(first, width);
      n_cmp++; if (first != 3) begin n_bad++; $display("FAIL tick_delay got %0d want 3", first); end
      n_cmp++; if (width != 1) begin n_bad++; $display("FAIL tick_width got %0d want 1", width); end
      n_cmp++;
      if (pos_x !== 10'd385 || pos_y !== 10'd285) begin
        n_bad++; $display("FAIL idle_pos got (%0d,%0d) want (385,285)", pos_x, pos_y);
      end
    end
  endtask

  task automatic test_manual;
    int first, width;
    set_keys(5'b10111);  // right
    for (int f = 0; f < 10; f++) run_frame(first, width);
    n_cmp++; if (pos_x !== 10'd405) begin n_bad++; $display("FAIL right10 got %0d want 405", pos_x); end
    set_keys(5'b10011);  // left + right
    for (int f = 0; f < 3; f++) begin
      run_frame(first, width);
      n_cmp++; if (pos_x !== 10'd405) begin n_bad++; $display("FAIL left_right got %0d want 405", pos_x); end
    end
    set_keys(5'b10111);
    for (int f = 0; f < 71; f++) run_frame(first, width);
    n_cmp++; if (pos_x !== 10'd547) begin n_bad++; $display("FAIL right_to_547 got %0d want 547", pos_x); end
    for (int f = 0; f < 3; f++) begin
      run_frame(first, width);
      n_cmp++; if (pos_x !== 10'd549) begin n_bad++; $display("FAIL sat_549 got %0d want 549", pos_x); end
    end
    set_keys(5'b11110);  // up
    for (int f = 0; f < 2; f++) run_frame(first, width);
    n_cmp++; if (pos_y !== 10'd281) begin n_bad++; $display("FAIL up2 got %0d want 281", pos_y); end
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL manual_sat_hit got %b want 0", hit); end
    set_keys(5'b11111);
  endtask

  task automatic test_auto_bounce;
    int first, width;
    logic hit_exp, chk;
    int ex, ey;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    auto_mode = 1'b1;
    tick(3);
    for (int f = 1; f <= 89; f++) begin
      run_frame(first, width);
      hit_exp = HitEn && ((f >= 62 && f <= 68) || (f >= 82 && f <= 88));
      n_cmp++;
      if (hit !== hit_exp) begin n_bad++; $display("FAIL hit_f%0d got %b want %b", f, hit, hit_exp); end
      chk = 1'b1;
      case (f)
        1:  begin ex = 387; ey = 287; end
        62: begin ex = 509; ey = 409; end
        63: begin ex = 511; ey = 407; end
        69: begin ex = 523; ey = 395; end
        81: begin ex = 547; ey = 371; end
        82: begin ex = 549; ey = 369; end
        83: begin ex = 547; ey = 367; end
        89: begin ex = 535; ey = 355; end
        default: begin chk = 1'b0; ex = 0; ey = 0; end
      endcase
      if (chk) begin
        n_cmp++;
        if (pos_x !== 10'(ex) || pos_y !== 10'(ey)) begin
          n_bad++;
          $display("FAIL auto_f%0d got (%0d,%0d) want (%0d,%0d)", f, pos_x, pos_y, ex, ey);
        end
      end
    end
  endtask

  task automatic test_pause;
    int first, width;
    set_keys(5'b01111);
    set_keys(5'b11111);
    for (int f = 0; f < 5; f++) begin
      run_frame(first, width);
      n_cmp++;
      if (pos_x !== 10'd535 || pos_y !== 10'd355) begin
        n_bad++; $display("FAIL paused got (%0d,%0d) want (535,355)", pos_x, pos_y);
      end
    end
    set_keys(5'b01111);
    set_keys(5'b11111);
    run_frame(first, width);
    n_cmp++;
    if (pos_x !== 10'd533 || pos_y !== 10'd353) begin
      n_bad++; $display("FAIL resume1 got (%0d,%0d) want (533,353)", pos_x, pos_y);
    end
    run_frame(first, width);
    n_cmp++;
    if (pos_x !== 10'd531 || pos_y !== 10'd351) begin
      n_bad++; $display("FAIL resume2 got (%0d,%0d) want (531,351)", pos_x, pos_y);
    end
  endtask

  task automatic test_reset_mid;
    int first, width;
    @(posedge clk);
    #1 vsync = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pos_x !== 10'd385 || pos_y !== 10'd285) begin
      n_bad++; $display("FAIL midrst_pos got (%0d,%0d) want (385,285)", pos_x, pos_y);
    end
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL midrst_hit got %b want 0", hit); end
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL midrst_state got %0d want 0", dut.state_q); end
    tick(3);
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL midrst_tick got %b want 0", frame_tick); end
    vsync = 1'b1;
    auto_mode = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL post_rst_state got %0d want 0", dut.state_q); end
    run_frame(first, width);
    n_cmp++; if (first != 3) begin n_bad++; $display("FAIL post_rst_tick got %0d want 3", first); end
    n_cmp++;
    if (pos_x !== 10'd385 || pos_y !== 10'd285) begin
      n_bad++; $display("FAIL post_rst_pos got (%0d,%0d) want (385,285)", pos_x, pos_y);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_bounce();
    test_pause();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_pos_ctrl.md
Name: sprite_pos_ctrl

Overview:
- Upstream feeder of the 800x600 VGA display stage (50 MHz pixel clock, 1040x666 total, active-low hsync/vsync).
- Produces the top-left pixel position of the 31x31 marker square that the display stage draws inside the blue/green frame.
- Updates once per frame, on the vsync falling edge.
- Supports manual motion from four pushbuttons, or autonomous bouncing, with pause.

Parameters:
- X_MIN, 221, leftmost allowed pos_x (first interior column of frame).
- X_MAX, 549, rightmost allowed pos_x (579 - 30).
- Y_MIN, 161, topmost allowed pos_y.
- Y_MAX, 409, bottommost allowed pos_y (439 - 30).
- X_INIT, 385, reset pos_x.
- Y_INIT, 285, reset pos_y.
- STEP, 2, pixels moved per frame per axis (1..15).
- DEB_CYCLES, 1000000, debounce sample period in clk cycles (20 ms).

Ports:
- clk  in  1  50 MHz clock
- rst_n  in  1  async reset, active-low
- vsync  in  1  active-low vsync from display timing
- key_n  in  5  raw active-low buttons: [0] up, [1] down, [2] left, [3] right, [4] pause
- auto_mode  in  1  1 = bounce mode, 0 = manual mode
- pos_x  out  10  marker left column, display xpos coordinates
- pos_y  out  10  marker top row, display ypos coordinates
- frame_tick  out  1  one-cycle pulse per vsync falling edge
- hit  out  1  wall-contact indicator (see Optional Feature)

Behaviour:
- Reset: already decided — reset rst_n, asynchronous, active-low; clock clk.
- Reset values: pos_x=X_INIT, pos_y=Y_INIT, frame_tick=0, hit=0, state=S_MANUAL, dir_x=+1, dir_y=+1, debounced keys all released.
- Reset asserted mid-frame or mid-debounce restores all of the above immediately.
- vsync handling:
  - 2-flop synchronizer, then falling-edge detect.
  - frame_tick asserts 3 clk cycles after the vsync high-to-low transition, for exactly 1 cycle.
- Debounce:
  - key_n passes through a 2-flop synchronizer.
  - A free-running counter wraps at DEB_CYCLES-1 and produces a sample strobe at the wrap.
  - Keys are sampled on the strobe; a key is "held" when the two most recent samples are both 0.
  - pause_evt = one-cycle pulse on the released-to-held transition of key[4].
- FSM (S_MANUAL, S_AUTO, S_PAUSE); transitions evaluated every cycle:
  - S_MANUAL -> S_AUTO when auto_mode=1.
  - S_AUTO -> S_MANUAL when auto_mode=0.
  - S_AUTO -> S_PAUSE on pause_evt.
  - S_PAUSE -> S_AUTO on pause_evt.
  - S_PAUSE -> S_MANUAL when auto_mode=0.
  - When auto_mode=0 and pause_evt coincide, auto_mode wins.
- Motion: position registers change only on a cycle where frame_tick=1; the new value is visible the next cycle.
- S_MANUAL motion:
  - x moves -STEP if left held, +STEP if right held.
  - y moves -STEP if up held, +STEP if down held.
  - Opposing keys both held: no motion on that axis.
  - Results saturate to [MIN, MAX].
- S_AUTO motion:
  - Per axis, next = pos + STEP*dir, computed in 11-bit signed arithmetic.
  - If next > MAX: pos = MAX and dir becomes -1.
  - If next < MIN: pos = MIN and dir becomes +1.
  - If next equals a bound exactly: pos = that bound and dir flips.
  - Otherwise pos = next.
- S_PAUSE: position and dir frozen.
- Direction registers persist across mode changes.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SPRITE_HIT_FLAG_EN.
- Defined:
  - Any axis direction flip in S_AUTO loads a 3-bit frame counter with 7; hit=1 while the counter is nonzero.
  - The counter decrements on each later frame_tick.
  - A new flip while the counter is nonzero reloads it to 7.
  - Manual saturation does not set hit.
- Undefined: no counter; hit tied to 0.

Decomposition:
- Package sprite_pkg holds:
  - FSM state encoding (2-bit: S_MANUAL=0, S_AUTO=1, S_PAUSE=2).
  - Key index constants (KEY_UP..KEY_PAUSE).
  - Default frame-interior bounds shared with the display stage.
- One sub-module: key_debounce (synchronizer, sample strobe, held/edge outputs for N keys), parameterised by width and DEB_CYCLES.

Test Plan (DEB_CYCLES=4, STEP=2):
- Reset released, 3 vsync falls, no keys -> frame_tick pulses 3 times, each 1 cycle wide and 3 clk after the fall; pos stays (385,285).
- Manual, right held 10 frames -> pos_x=405; left+right held together -> pos_x unchanged.
- Manual, pos_x=547, right held 3 frames -> 549, 549, 549.
- auto_mode=1 from (385,285) -> after 1 frame (387,287); once pos_x reaches 549, next frame 547 with dir_x=-1; hit=1 for 7 frames when macro defined, hit stays 0 when undefined.
- Auto, pause pressed -> 5 frames with no motion; pause pressed again -> motion resumes from the frozen point with the same dir.
- rst_n asserted mid-frame in S_AUTO at (500,300) -> immediately (385,285), S_MANUAL, hit=0.
